// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MWAIT = 2'd3
    } state_e;

    localparam int unsigned MEM_TMO_DEF = 15;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned TMR_W       = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent in MWAIT and flags the cycle in which the wait budget runs out.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TMO = MEM_TMO_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_mwait,
    output logic timeout_c
);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    // Count while waiting (saturating); any other state reloads zero for the next entry.
    always_comb begin
        timer_d = '0;
        if (in_mwait) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // The current MWAIT cycle is the MEM_TMO-th one.
    assign timeout_c = in_mwait && ((32'(timer_q) + 32'd1) >= MEM_TMO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait holds, taken-branch flushes and RAW handling.
// Define HAZ_FWD_EN to resolve RAW hazards by forwarding instead of a one-cycle stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TMO = MEM_TMO_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s2_valid,
    input  logic             s2_rd_en,
    input  logic [2:0]       s2_rd_addr,
    input  logic             s3_valid,
    input  logic             s3_wr_en,
    input  logic [2:0]       s3_wr_addr,
    input  logic             s3_taken,
    input  logic             s3_mem,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             hold_s2,
    output logic             flush_s1,
    output logic             flush_s2,
    output logic             bubble_s3,
    output logic             fwd_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             mem_err_q;
    logic             mem_err_d;
    logic             timeout_c;
    logic             mem_wait_c;
    logic             taken_c;
    logic             raw_c;

    assign mem_wait_c = s3_valid & s3_mem & ~mem_ready;
    assign taken_c    = s3_valid & s3_taken;
    assign raw_c      = s2_valid & s2_rd_en & s3_valid & s3_wr_en & (s2_rd_addr == s3_wr_addr);

    mem_wait_timer #(
        .MEM_TMO (MEM_TMO)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .in_mwait  (state_q == ST_MWAIT),
        .timeout_c (timeout_c)
    );

    // Next state, Mealy pipeline controls and registered-status updates.
    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        hold_pc   = 1'b0;
        hold_s2   = 1'b0;
        flush_s1  = 1'b0;
        flush_s2  = 1'b0;
        bubble_s3 = 1'b0;
        fwd_sel   = 1'b0;
        if (rst) begin
            state_d  = ST_RUN;
            flush_s1 = 1'b1;
            flush_s2 = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait_c) begin
                        hold_pc = 1'b1;
                        hold_s2 = 1'b1;
                        state_d = ST_MWAIT;
                    end else if (taken_c) begin
                        flush_s1 = 1'b1;
                        flush_s2 = 1'b1;
                        state_d  = ST_FLUSH;
                    end else if (raw_c) begin
`ifdef HAZ_FWD_EN
                        fwd_sel = 1'b1;
`else
                        hold_pc   = 1'b1;
                        hold_s2   = 1'b1;
                        bubble_s3 = 1'b1;
                        state_d   = ST_STALL;
`endif
                    end
                end
                ST_STALL: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    flush_s2 = 1'b1;
                    state_d  = ST_RUN;
                end
                ST_MWAIT: begin
                    if (mem_ready) begin
                        state_d = ST_RUN;
                        if (taken_c) begin
                            flush_s1 = 1'b1;
                            flush_s2 = 1'b1;
                            state_d  = ST_FLUSH;
                        end
                    end else if (timeout_c) begin
                        bubble_s3 = 1'b1;
                        mem_err_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        hold_pc = 1'b1;
                        hold_s2 = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
        stall_cnt_d = (hold_pc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: a default instance and a short-timeout,
// narrow-counter instance share stimulus and are checked against a cycle model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s2_valid = 1'b0, s2_rd_en = 1'b0, s3_valid = 1'b0, s3_wr_en = 1'b0;
    logic       s3_taken = 1'b0, s3_mem = 1'b0, mem_ready = 1'b1;
    logic [2:0] s2_rd_addr = 3'd0, s3_wr_addr = 3'd0;

    logic       a_hold_pc, a_hold_s2, a_flush_s1, a_flush_s2, a_bubble_s3, a_fwd_sel, a_mem_err;
    logic [7:0] a_stall_cnt;
    logic [1:0] a_state;
    logic       b_hold_pc, b_hold_s2, b_flush_s1, b_flush_s2, b_bubble_s3, b_fwd_sel, b_mem_err;
    logic [3:0] b_stall_cnt;
    logic [1:0] b_state;

    int n_chk  = 0;
    int n_pass = 0;

    // model state per instance: 0 = default build, 1 = MEM_TMO 3 / CNT_W 4
    int tmo  [2] = '{15, 3};
    int cmax [2] = '{255, 15};
    bit waiting [2];
    int wait_n  [2];
    bit flushing[2];
    bit recover [2];
    bit err     [2];
    int cnt     [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut_a (
        .clk(clk), .rst(rst),
        .s2_valid(s2_valid), .s2_rd_en(s2_rd_en), .s2_rd_addr(s2_rd_addr),
        .s3_valid(s3_valid), .s3_wr_en(s3_wr_en), .s3_wr_addr(s3_wr_addr),
        .s3_taken(s3_taken), .s3_mem(s3_mem), .mem_ready(mem_ready),
        .hold_pc(a_hold_pc), .hold_s2(a_hold_s2), .flush_s1(a_flush_s1), .flush_s2(a_flush_s2),
        .bubble_s3(a_bubble_s3), .fwd_sel(a_fwd_sel), .mem_err(a_mem_err),
        .stall_cnt(a_stall_cnt), .state(a_state)
    );

    pipe_hazard_ctrl #(.MEM_TMO(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .s2_valid(s2_valid), .s2_rd_en(s2_rd_en), .s2_rd_addr(s2_rd_addr),
        .s3_valid(s3_valid), .s3_wr_en(s3_wr_en), .s3_wr_addr(s3_wr_addr),
        .s3_taken(s3_taken), .s3_mem(s3_mem), .mem_ready(mem_ready),
        .hold_pc(b_hold_pc), .hold_s2(b_hold_s2), .flush_s1(b_flush_s1), .flush_s2(b_flush_s2),
        .bubble_s3(b_bubble_s3), .fwd_sel(b_fwd_sel), .mem_err(b_mem_err),
        .stall_cnt(b_stall_cnt), .state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference behaviour for one cycle of instance i; compares then advances the model.
    task automatic model_cycle(input int i);
        bit hp, hs, f1, f2, bb, fw, mwait, taken, raw;
        logic [31:0] got_ctl, got_state, got_cnt, got_err;
        int exp_state;
        hp = 0; hs = 0; f1 = 0; f2 = 0; bb = 0; fw = 0;
        mwait = s3_valid && s3_mem && !mem_ready;
        taken = s3_valid && s3_taken;
        raw   = s2_valid && s2_rd_en && s3_valid && s3_wr_en && (s2_rd_addr == s3_wr_addr);
        exp_state = waiting[i] ? 3 : flushing[i] ? 2 : recover[i] ? 1 : 0;

        if (i == 0) begin
            got_ctl   = 32'({a_hold_pc, a_hold_s2, a_flush_s1, a_flush_s2, a_bubble_s3, a_fwd_sel});
            got_state = 32'(a_state); got_cnt = 32'(a_stall_cnt); got_err = 32'(a_mem_err);
        end else begin
            got_ctl   = 32'({b_hold_pc, b_hold_s2, b_flush_s1, b_flush_s2, b_bubble_s3, b_fwd_sel});
            got_state = 32'(b_state); got_cnt = 32'(b_stall_cnt); got_err = 32'(b_mem_err);
        end
        check($sformatf("state%0d", i), got_state, 32'(exp_state));
        check($sformatf("stall_cnt%0d", i), got_cnt, 32'(cnt[i]));
        check($sformatf("mem_err%0d", i), got_err, 32'(err[i]));

        if (rst) begin
            f1 = 1; f2 = 1;
            waiting[i] = 0; wait_n[i] = 0; flushing[i] = 0; recover[i] = 0; err[i] = 0;
        end else if (flushing[i]) begin
            f2 = 1; flushing[i] = 0;
        end else if (recover[i]) begin
            recover[i] = 0;
        end else if (waiting[i]) begin
            if (mem_ready) begin
                waiting[i] = 0;
                if (taken) begin f1 = 1; f2 = 1; flushing[i] = 1; end
            end else if (wait_n[i] + 1 >= tmo[i]) begin
                bb = 1; err[i] = 1; waiting[i] = 0;
            end else begin
                hp = 1; hs = 1; wait_n[i]++;
            end
        end else if (mwait) begin
            hp = 1; hs = 1; waiting[i] = 1; wait_n[i] = 0;
        end else if (taken) begin
            f1 = 1; f2 = 1; flushing[i] = 1;
        end else if (raw) begin
`ifdef HAZ_FWD_EN
            fw = 1;
`else
            hp = 1; hs = 1; bb = 1; recover[i] = 1;
`endif
        end
        check($sformatf("ctl%0d", i), got_ctl, 32'({hp, hs, f1, f2, bb, fw}));

        if (rst)     cnt[i] = 0;
        else if (hp) cnt[i] = (cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i];
    endtask

    // Drive one cycle of inputs mid-period, then check both instances.
    task automatic step(input bit r, input bit v2, input bit re, input bit [2:0] ra,
                        input bit v3, input bit we, input bit [2:0] wa,
                        input bit tk, input bit mm, input bit rdy);
        @(negedge clk);
        rst = r; s2_valid = v2; s2_rd_en = re; s2_rd_addr = ra;
        s3_valid = v3; s3_wr_en = we; s3_wr_addr = wa;
        s3_taken = tk; s3_mem = mm; mem_ready = rdy;
        #1;
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic idle();
        step(0, 0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1);
        step(1, 0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            waiting[i] = 0; wait_n[i] = 0; flushing[i] = 0; recover[i] = 0; err[i] = 0; cnt[i] = 0;
        end
        @(posedge clk);

        // reset, then release
        do_reset();
        check("rst_flush_s1", 32'(a_flush_s1), 32'd1);
        idle();
        check("rst_state", 32'(a_state), 32'd0);

        // taken jump pulse
        step(0, 0, 0, 3'd0, 1, 0, 3'd0, 1, 0, 1);
        idle();
        idle();

        // RAW hazard on R5
        step(0, 1, 1, 3'd5, 1, 1, 3'd5, 0, 0, 1);
        idle();
        idle();

        // memory wait: four cycles not ready, then ready
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 0);
        step(0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 1);
        idle();
        check("mw_stall_cnt", 32'(a_stall_cnt), 32'd4);

        // timeout on the short-timeout instance
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 0);
        idle();
        check("tmo_err", 32'(b_mem_err), 32'd1);
        for (int k = 0; k < 3; k++) idle();
        check("tmo_err_sticky", 32'(b_mem_err), 32'd1);

        // memory wait together with taken and RAW
        do_reset();
        step(0, 1, 1, 3'd2, 1, 1, 3'd2, 1, 1, 0);
        step(0, 1, 1, 3'd2, 1, 1, 3'd2, 1, 1, 0);
        step(0, 1, 1, 3'd2, 1, 1, 3'd2, 1, 1, 1);
        idle();
        idle();

        // reset abandons a pending memory wait
        step(0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 0);
        step(1, 0, 0, 3'd0, 1, 0, 3'd0, 0, 1, 0);
        idle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit [2:0] ra, wa;
            ra = 3'($urandom);
            wa = ($urandom_range(0, 2) == 0) ? ra : 3'($urandom);
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wa,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TMO, default 15: maximum data-memory wait cycles before abort (range 1..255).
REQ-002 Parameter CNT_W, default 8: width of the stall counter.
REQ-003 One clock; reset is synchronous and active-high. Port clk is the clock and port rst is the reset.
REQ-004 Ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s2_valid  in  1  stage-2 slot holds a live instruction.
- s2_rd_en  in  1  stage-2 instruction reads Rn.
- s2_rd_addr  in  3  Rn index read in stage 2.
- s3_valid  in  1  stage-3 slot holds a live instruction.
- s3_wr_en  in  1  stage-3 instruction writes Rn.
- s3_wr_addr  in  3  Rn index written in stage 3.
- s3_taken  in  1  stage 3 loads PC (L_PC after flag qualification).
- s3_mem  in  1  stage 3 drives RD or WR to data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- hold_pc  out  1  PC and stage-1 register keep their value.
- hold_s2  out  1  stage-2 register keeps its value.
- flush_s1  out  1  stage-1 register loads NOP (8'h00 opcode).
- flush_s2  out  1  stage-2 register loads NOP.
- bubble_s3  out  1  stage-3 control word forced to NOP.
- fwd_sel  out  1  stage-2 operand taken from the stage-3 result.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with hold_pc high.
- state  out  2  FSM state code.

Function
REQ-005 The FSM SHALL have four states: RUN=0, STALL=1, FLUSH=2, MWAIT=3.
REQ-006 The hold, flush, bubble and fwd_sel outputs SHALL be combinational functions of state and current inputs (Mealy). state, stall_cnt and mem_err SHALL be registered.
REQ-007 In RUN, events SHALL be evaluated in priority order: memory wait, then taken transfer, then RAW hazard.
REQ-008 Memory wait is s3_valid & s3_mem & !mem_ready. In that cycle hold_pc=hold_s2=1 and bubble_s3=0, and the next state is MWAIT.
REQ-009 In MWAIT, hold_pc and hold_s2 SHALL stay 1 until mem_ready=1. On mem_ready the holds drop in that same cycle and the next state is RUN. If s3_taken is still high, the taken rule of REQ-010 applies in that cycle.
REQ-010 Taken transfer is s3_valid & s3_taken with no memory wait. It SHALL assert flush_s1=flush_s2=1 in that cycle, then spend one cycle in FLUSH with flush_s2=1, then return to RUN.
REQ-011 RAW hazard is s2_valid & s2_rd_en & s3_valid & s3_wr_en & (s2_rd_addr==s3_wr_addr).
REQ-012 In FLUSH, the memory-wait and RAW rules SHALL be ignored. Only flush_s2 is asserted.
REQ-013 The MWAIT timer SHALL count cycles spent in MWAIT. When it reaches MEM_TMO without mem_ready, the block SHALL set mem_err, assert bubble_s3 for one cycle, release the holds and go to RUN.
REQ-014 mem_err SHALL clear only on rst.
REQ-015 stall_cnt SHALL increment on every cycle with hold_pc=1 and SHALL saturate at all-ones, with no wrap.
REQ-016 The timer SHALL reload to 0 on every entry to MWAIT.

Reset
REQ-017 While rst=1: state=RUN, stall_cnt=0, mem_err=0, timer=0, flush_s1=flush_s2=1, all other outputs 0.
REQ-018 If rst is asserted in any state, including MWAIT and STALL, the block SHALL abandon the pending event and return to RUN on the next edge, with no residual flush or hold.

Configuration
REQ-019 The macro HAZ_FWD_EN SHALL control RAW-hazard handling.
REQ-020 With HAZ_FWD_EN defined, a RAW hazard in RUN SHALL assert fwd_sel=1 in the same cycle, with no hold and state unchanged. STALL is unreachable.
REQ-021 Without HAZ_FWD_EN, fwd_sel SHALL be tied to 0. A RAW hazard SHALL assert hold_pc=hold_s2=bubble_s3=1 for exactly one cycle (state STALL), then return to RUN.

Structure
REQ-022 Package pipe_ctrl_pkg SHALL hold the state enum, its encodings and the default MEM_TMO/CNT_W constants.
REQ-023 A single sub-module, mem_wait_timer, SHALL contain the MWAIT cycle counter and the timeout compare. All other logic SHALL reside in pipe_hazard_ctrl.

Verification
REQ-024 Reset: with rst high for 2 cycles, flush_s1=flush_s2=1 and stall_cnt=0; after release, state=0.
REQ-025 Taken jump: pulse s3_valid=s3_taken=1 for one cycle. Required: flush_s1=flush_s2=1 in that cycle, flush_s2 only in the next cycle, then RUN.
REQ-026 RAW hazard with s2_rd_addr=s3_wr_addr=3'd5:
- Without HAZ_FWD_EN: one cycle of hold_pc=hold_s2=bubble_s3=1, and stall_cnt increments by 1.
- With HAZ_FWD_EN: fwd_sel=1 and no holds.
REQ-027 Memory wait: s3_mem=1 with mem_ready low for 4 cycles, then high. Required: holds for 4 cycles, release in the mem_ready cycle, stall_cnt=4.
REQ-028 Timeout with MEM_TMO=3 and mem_ready stuck at 0: mem_err=1 after 3 MWAIT cycles, one bubble_s3 pulse, RUN. mem_err stays 1 until rst.
REQ-029 Simultaneous events: s3_mem=1 with mem_ready low, plus s3_taken=1 and a RAW hazard. Required: MWAIT first. When mem_ready=1, flush_s1/flush_s2 assert, and no STALL occurs.
